perceptron_trainer: RTL and testbench

//  Training sequencer that drives the perceptron's sample interface. Buffers a labelled

---
 rtl/perceptron_trainer_if.sv | 39 +++
 rtl/perceptron_trainer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_trainer_if.sv
// -----------------------------------------------------------------------------
// perceptron_trainer_if
// Groups the dataset-load handshake and the perceptron sample bus used by
// perceptron_trainer.
//   slave  : the trainer (receives dataset samples, drives the perceptron)
//   master : the environment (dataset loader + perceptron instance)
// Signals
//   load_valid/load_ready/load_values/load_expected/load_last : dataset channel
//   p_rst/p_training/p_values/p_expected/p_learning_rate      : to perceptron
//   p_prediction                                              : from perceptron
// Values are signed fixed point (sfp), SFP_W bits wide.
// -----------------------------------------------------------------------------
interface perceptron_trainer_if #(
  parameter int INPUT_UNITS = 2,
  parameter int SFP_W       = 16
);
  logic                               load_valid;
  logic                               load_ready;
  logic [INPUT_UNITS-1:0][SFP_W-1:0]  load_values;
  logic [SFP_W-1:0]                   load_expected;
  logic                               load_last;

  logic                               p_rst;
  logic                               p_training;
  logic [INPUT_UNITS-1:0][SFP_W-1:0]  p_values;
  logic [SFP_W-1:0]                   p_expected;
  logic [SFP_W-1:0]                   p_learning_rate;
  logic [SFP_W-1:0]                   p_prediction;

  modport master (
    output load_valid, load_values, load_expected, load_last, p_prediction,
    input  load_ready, p_rst, p_training, p_values, p_expected, p_learning_rate
  );

  modport slave (
    input  load_valid, load_values, load_expected, load_last, p_prediction,
    output load_ready, p_rst, p_training, p_values, p_expected, p_learning_rate
  );
endinterface

// File: rtl/perceptron_trainer.sv
// -----------------------------------------------------------------------------
// perceptron_trainer
// Training sequencer for one perceptron. Buffers a labelled dataset, then
// replays it in epochs (one sample per cycle with p_training=1), counts
// misclassifications from the returned prediction and stops on a zero-error
// epoch or after MAX_EPOCHS epochs.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-low reset
//   bus            perceptron_trainer_if.slave (dataset load + perceptron bus)
//   start          begin training (pulse)
//   learning_rate  captured on start (in CLEAR)
//   busy           CLEAR/TRAIN/EVAL (and VERIFY/VEVAL) active
//   done           1-cycle pulse at end of training
//   converged      last run ended on a zero-error epoch
//   epoch_count    epochs completed in current/last run
//   epoch_errors   error count of the last completed epoch
//
// Optional feature: define PERCEPTRON_TRAINER_VERIFY_EN to add a read-only
// verification pass after a zero-error epoch.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a sample or a start
// LOAD   | dataset load in progress
// CLEAR  | p_rst to perceptron, clear counters, latch learning rate
// TRAIN  | replay sample idx with p_training=1, accumulate errors
// EVAL   | close epoch, decide converge / give up / next epoch
// VERIFY | (optional) replay samples with p_training=0, count errors
// VEVAL  | (optional) publish verify result
// DONE   | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module perceptron_trainer #(
  parameter int INPUT_UNITS = 2,
  parameter int MAX_SAMPLES = 16,
  parameter int MAX_EPOCHS  = 255,
  parameter int SFP_W       = 16,
  localparam int CNT_W      = $clog2(MAX_SAMPLES + 1),
  localparam int EPC_W      = $clog2(MAX_EPOCHS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  perceptron_trainer_if.slave         bus,
  input  logic                        start,
  input  logic [SFP_W-1:0]            learning_rate,
  output logic                        busy,
  output logic                        done,
  output logic                        converged,
  output logic [EPC_W-1:0]            epoch_count,
  output logic [CNT_W-1:0]            epoch_errors
);

  localparam int IDX_W = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;

  typedef logic [INPUT_UNITS-1:0][SFP_W-1:0] vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_TRAIN,
    S_EVAL,
    S_DONE
`ifdef PERCEPTRON_TRAINER_VERIFY_EN
    , S_VERIFY,
    S_VEVAL
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   sample_count_q, sample_count_d;
  logic               complete_q, complete_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [EPC_W-1:0]   epoch_count_q, epoch_count_d;
  logic [CNT_W-1:0]   epoch_errors_q, epoch_errors_d;
  logic               converged_q, converged_d;
  logic [SFP_W-1:0]   lr_q, lr_d;
  // Holds load_ready low while in reset and until the first clock after release.
  logic               ready_en_q;

  vec_t               val_mem [MAX_SAMPLES];
  logic [SFP_W-1:0]   exp_mem [MAX_SAMPLES];

  logic               load_ready;
  logic               xfer;
  logic               restart;
  logic [IDX_W-1:0]   wr_idx;
  logic [CNT_W-1:0]   count_after;
  logic               ends_dataset;
  logic               replay;
  logic               mismatch;
  logic               last_idx;

  // ---------------------------------------------------------------------------
  // Dataset buffer
  // ---------------------------------------------------------------------------
  assign load_ready = ready_en_q
                    && (state_q == S_IDLE || state_q == S_LOAD)
                    && (sample_count_q < CNT_W'(MAX_SAMPLES));
  assign xfer       = bus.load_valid && load_ready;

  // A new transfer in IDLE after a finished dataset overwrites from index 0.
  assign restart      = (state_q == S_IDLE) && complete_q;
  assign wr_idx       = restart ? '0 : sample_count_q[IDX_W-1:0];
  assign count_after  = restart ? CNT_W'(1) : sample_count_q + CNT_W'(1);
  assign ends_dataset = bus.load_last || (count_after == CNT_W'(MAX_SAMPLES));

  always_ff @(posedge clk) begin
    if (xfer) begin
      val_mem[wr_idx] <= bus.load_values;
      exp_mem[wr_idx] <= bus.load_expected;
    end
  end

  // ---------------------------------------------------------------------------
  // Replay datapath
  // ---------------------------------------------------------------------------
`ifdef PERCEPTRON_TRAINER_VERIFY_EN
  assign replay = (state_q == S_TRAIN) || (state_q == S_VERIFY);
`else
  assign replay = (state_q == S_TRAIN);
`endif

  // Prediction is compared against the label before the perceptron updates.
  assign mismatch = (bus.p_prediction != exp_mem[idx_q]);
  assign last_idx = (CNT_W'(idx_q) == (sample_count_q - CNT_W'(1)));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      sample_count_q <= '0;
      complete_q     <= 1'b0;
      idx_q          <= '0;
      acc_q          <= '0;
      epoch_count_q  <= '0;
      epoch_errors_q <= '0;
      converged_q    <= 1'b0;
      lr_q           <= '0;
      ready_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_count_q <= sample_count_d;
      complete_q     <= complete_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      epoch_count_q  <= epoch_count_d;
      epoch_errors_q <= epoch_errors_d;
      converged_q    <= converged_d;
      lr_q           <= lr_d;
      ready_en_q     <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    sample_count_d = sample_count_q;
    complete_d     = complete_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    epoch_count_d  = epoch_count_q;
    epoch_errors_d = epoch_errors_q;
    converged_d    = converged_q;
    lr_d           = lr_q;

    case (state_q)
      S_IDLE: begin
        // A load transfer takes priority over a coincident start.
        if (xfer) begin
          sample_count_d = count_after;
          complete_d     = ends_dataset;
          state_d        = ends_dataset ? S_IDLE : S_LOAD;
        end else if (start && (sample_count_q != '0)) begin
          state_d = S_CLEAR;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          sample_count_d = count_after;
          if (ends_dataset) begin
            complete_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      S_CLEAR: begin
        epoch_count_d  = '0;
        epoch_errors_d = '0;
        converged_d    = 1'b0;
        acc_d          = '0;
        idx_d          = '0;
        lr_d           = learning_rate;
        state_d        = S_TRAIN;
      end

      S_TRAIN: begin
        acc_d = acc_q + CNT_W'(mismatch);
        if (last_idx) begin
          idx_d   = '0;
          state_d = S_EVAL;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_EVAL: begin
        epoch_errors_d = acc_q;
        epoch_count_d  = epoch_count_q + EPC_W'(1);
        acc_d          = '0;
        if (acc_q == '0) begin
`ifdef PERCEPTRON_TRAINER_VERIFY_EN
          state_d = S_VERIFY;
`else
          converged_d = 1'b1;
          state_d     = S_DONE;
`endif
        end else if (epoch_count_q == EPC_W'(MAX_EPOCHS - 1)) begin
          converged_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          state_d = S_TRAIN;
        end
      end

`ifdef PERCEPTRON_TRAINER_VERIFY_EN
      S_VERIFY: begin
        acc_d = acc_q + CNT_W'(mismatch);
        if (last_idx) begin
          idx_d   = '0;
          state_d = S_VEVAL;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_VEVAL: begin
        epoch_errors_d = acc_q;
        converged_d    = (acc_q == '0);
        acc_d          = '0;
        state_d        = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.load_ready      = load_ready;
  assign bus.p_rst           = (state_q == S_CLEAR);
  assign bus.p_training      = (state_q == S_TRAIN);
  assign bus.p_values        = replay ? val_mem[idx_q] : '0;
  assign bus.p_expected      = replay ? exp_mem[idx_q] : '0;
  assign bus.p_learning_rate = lr_q;

  assign busy         = !(state_q == S_IDLE || state_q == S_LOAD || state_q == S_DONE);
  assign done         = (state_q == S_DONE);
  assign converged    = converged_q;
  assign epoch_count  = epoch_count_q;
  assign epoch_errors = epoch_errors_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// -----------------------------------------------------------------------------
// tb_perceptron_trainer
// Directed bench for perceptron_trainer with a behavioural perceptron attached
// (strict threshold: prediction 1.0 when w.x + b > 0). Expected epoch counts
// for AND come from a hand trace of that perceptron over the sample order
// (0,0)->0, (0,1)->0, (1,0)->0, (1,1)->1 with lr=1.0: converges on epoch 6.
// -----------------------------------------------------------------------------
module tb_perceptron_trainer;

  localparam int IU    = 2;
  localparam int SW    = 16;
  localparam int MS    = 16;
  localparam int ME    = 8;
  localparam int CW    = $clog2(MS + 1);
  localparam int EW    = $clog2(ME + 1);
  localparam logic [SW-1:0] ONE = 16'h0100;
`ifdef PERCEPTRON_TRAINER_VERIFY_EN
  localparam int VON = 1;
`else
  localparam int VON = 0;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic [SW-1:0]  learning_rate;
  logic           busy;
  logic           done;
  logic           converged;
  logic [EW-1:0]  epoch_count;
  logic [CW-1:0]  epoch_errors;

  int n_tests = 0;
  int n_fail  = 0;

  perceptron_trainer_if #(.INPUT_UNITS(IU), .SFP_W(SW)) bus ();

  perceptron_trainer #(
    .INPUT_UNITS(IU),
    .MAX_SAMPLES(MS),
    .MAX_EPOCHS (ME),
    .SFP_W      (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .start        (start),
    .learning_rate(learning_rate),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .epoch_count  (epoch_count),
    .epoch_errors (epoch_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural perceptron (integer-valued weights, lr integer in sfp units)
  // ---------------------------------------------------------------------------
  int w0 = 0, w1 = 0, wb = 0;
  int x0, x1, ev, lr, sum, pv;
  logic [SW-1:0] pred;

  always_comb begin
    x0   = int'($signed(bus.p_values[0])) / 256;
    x1   = int'($signed(bus.p_values[1])) / 256;
    ev   = int'($signed(bus.p_expected)) / 256;
    lr   = int'($signed(bus.p_learning_rate)) / 256;
    sum  = w0 * x0 + w1 * x1 + wb;
    pred = (sum > 0) ? ONE : '0;
    pv   = (sum > 0) ? 1 : 0;
  end

  assign bus.p_prediction = pred;

  always @(posedge clk) begin
    if (bus.p_rst) begin
      w0 <= 0;
      w1 <= 0;
      wb <= 0;
    end else if (bus.p_training) begin
      w0 <= w0 + lr * (ev - pv) * x0;
      w1 <= w1 + lr * (ev - pv) * x1;
      wb <= wb + lr * (ev - pv);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send(input int a, input int b, input int e, input logic last,
                      output logic accepted);
    bus.load_valid    = 1'b1;
    bus.load_values   = {SW'(b * 256), SW'(a * 256)};
    bus.load_expected = SW'(e * 256);
    bus.load_last     = last;
    accepted          = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (bus.load_ready) begin
        accepted = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  // Pulses start, then watches until done. poke >= 0 re-asserts start that many
  // cycles into the run.
  task automatic run_training(input int poke, output logic seen, output int busy_n,
                              output int train_n, output int prst_n);
    seen    = 1'b0;
    busy_n  = 0;
    train_n = 0;
    prst_n  = 0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 600; t++) begin
      start = (t == poke);
      if (busy) busy_n++;
      if (bus.p_training) train_n++;
      if (bus.p_rst) prst_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic acc;
  logic seen;
  int   busy_n, train_n, prst_n, n_acc;
  logic any_busy, any_done;

  initial begin
    rst               = 1'b0;
    start             = 1'b0;
    learning_rate     = ONE;
    bus.load_valid    = 1'b0;
    bus.load_values   = '0;
    bus.load_expected = '0;
    bus.load_last     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p_training", bus.p_training, 0);
    check("rst_p_rst", bus.p_rst, 0);
    check("rst_epoch_count", epoch_count, 0);
    check("rst_p_lr", bus.p_learning_rate, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_load_ready", bus.load_ready, 1);

    // Start with empty buffer is ignored
    any_busy = 1'b0;
    any_done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      any_busy |= busy;
      any_done |= done;
      @(negedge clk);
    end
    check("empty_start_busy", any_busy, 0);
    check("empty_start_done", any_done, 0);

    // AND dataset
    n_acc = 0;
    send(0, 0, 0, 1'b0, acc); n_acc += int'(acc);
    send(0, 1, 0, 1'b0, acc); n_acc += int'(acc);
    send(1, 0, 0, 1'b0, acc); n_acc += int'(acc);
    send(1, 1, 1, 1'b1, acc); n_acc += int'(acc);
    check("and_accepted", n_acc, 4);
    check("and_ready_after", bus.load_ready, 1);

    run_training(-1, seen, busy_n, train_n, prst_n);
    check("and_done", seen, 1);
    check("and_converged", converged, 1);
    check("and_epoch_count", epoch_count, 6);
    check("and_epoch_errors", epoch_errors, 0);
    check("and_busy_cycles", busy_n, 31 + 5 * VON);
    check("and_train_cycles", train_n, 24);
    check("and_prst_cycles", prst_n, 1);
    check("and_p_lr", bus.p_learning_rate, ONE);
    @(negedge clk);
    check("and_done_pulse", done, 0);
    check("and_idle_busy", busy, 0);
    check("and_hold_count", epoch_count, 6);

    // Same dataset again, start poked mid-run: must not disturb the run
    run_training(10, seen, busy_n, train_n, prst_n);
    check("poke_done", seen, 1);
    check("poke_busy_cycles", busy_n, 31 + 5 * VON);
    check("poke_epoch_count", epoch_count, 6);
    check("poke_prst_cycles", prst_n, 1);
    @(negedge clk);
    check("poke_done_pulse", done, 0);

    // XOR dataset; first transfer coincides with start (load wins)
    start = 1'b1;
    send(0, 0, 0, 1'b0, acc);
    start = 1'b0;
    check("xor_first_acc", acc, 1);
    check("xor_start_ignored", busy, 0);
    send(0, 1, 1, 1'b0, acc);
    send(1, 0, 1, 1'b0, acc);
    send(1, 1, 0, 1'b1, acc);
    check("xor_last_acc", acc, 1);

    run_training(-1, seen, busy_n, train_n, prst_n);
    check("xor_done", seen, 1);
    check("xor_converged", converged, 0);
    check("xor_epoch_count", epoch_count, ME);
    check("xor_err_nonzero", (epoch_errors != 0), 1);
    check("xor_busy_cycles", busy_n, 1 + ME * 5);
    check("xor_train_cycles", train_n, ME * 4);
    @(negedge clk);

    // Reset in the middle of TRAIN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_training", bus.p_training, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_training", bus.p_training, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", bus.load_ready, 0);
    check("mid_rst_p_values", bus.p_values, 0);
    check("mid_rst_p_lr", bus.p_learning_rate, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", bus.load_ready, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    any_busy = 1'b0;
    for (int t = 0; t < 3; t++) begin
      any_busy |= busy;
      @(negedge clk);
    end
    check("mid_dataset_gone", any_busy, 0);

    // Overflow: 20 offered, 16 accepted, never a load_last
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      send(i & 1, (i >> 1) & 1, 0, 1'b0, acc);
      n_acc += int'(acc);
    end
    check("full_accepted", n_acc, MS);
    check("full_ready_low", bus.load_ready, 0);

    run_training(-1, seen, busy_n, train_n, prst_n);
    check("full_done", seen, 1);
    check("full_converged", converged, 1);
    check("full_epoch_count", epoch_count, 1);
    check("full_busy_cycles", busy_n, 1 + (MS + 1) * (1 + VON));
    check("full_train_cycles", train_n, MS);
    @(negedge clk);
    check("full_ready_still_low", bus.load_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
